game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/jetpack_pkg.sv | 23 ++
 rtl/bcd_add_sat.sv | 38 +++
 rtl/game_sequencer.sv | 167 ++++++++++++++++
 tb/tb_game_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jetpack_pkg.sv
// Shared types and constants for the jetpack game sequencer.
package jetpack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int          WIDTH        = 640;
  localparam int          HEIGHT       = 480;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Taps 16,14,13,11 map to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [8:0]  SPAWN_Y_BASE = 9'd48;

  // One step of the 16-bit Fibonacci LFSR: shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Six-digit packed BCD plus 4-bit binary adder, saturating at 999999.
// Purely combinational; digit 0 sits in the low nibble.
module bcd_add_sat (
  input  logic [23:0] a_i,
  input  logic [3:0]  b_i,
  output logic [23:0] sum_o
);

  logic [4:0]  carry_s;
  logic [4:0]  digit_s;
  logic [23:0] raw_s;

  // Ripple the binary addend through the digits; the first digit can carry 2.
  always_comb begin
    carry_s = {1'b0, b_i};
    digit_s = 5'd0;
    raw_s   = 24'd0;
    for (int i = 0; i < 6; i++) begin
      digit_s = {1'b0, a_i[4*i +: 4]} + carry_s;
      if (digit_s >= 5'd20) begin
        raw_s[4*i +: 4] = 4'(digit_s - 5'd20);
        carry_s         = 5'd2;
      end else if (digit_s >= 5'd10) begin
        raw_s[4*i +: 4] = 4'(digit_s - 5'd10);
        carry_s         = 5'd1;
      end else begin
        raw_s[4*i +: 4] = digit_s[3:0];
        carry_s         = 5'd0;
      end
    end
    if (carry_s != 5'd0) begin
      sum_o = 24'h999999;
    end else begin
      sum_o = raw_s;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: frame tick, IDLE/PLAYING/DYING/OVER FSM, score, speed ramp
// and obstacle spawning. Define SEQ_HISCORE_EN to keep a high-score register.
module game_sequencer
  import jetpack_pkg::*;
#(
  parameter int DYING_FRAMES = 60,
  parameter int RAMP_FRAMES  = 600,
  parameter int SPEED_MAX    = 8,
  parameter int SPAWN_GAP    = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        start,
  input  logic        collision,
  output logic        frame_tick,
  output game_state_t state,
  output logic [3:0]  scroll_speed,
  output logic        freeze,
  output logic        spawn,
  output logic [8:0]  spawn_y,
  output logic [23:0] score,
  output logic [23:0] hiscore
);

  localparam int DW = $clog2(DYING_FRAMES + 1);
  localparam int RW = $clog2(RAMP_FRAMES + 1);
  localparam int SW = $clog2(SPAWN_GAP + 1);
  localparam logic [3:0] SPEED_TOP = 4'(SPEED_MAX);

  game_state_t   state_q, state_d;
  logic          at_end_s, at_end_q, tick_q, start_q, start_rise_s;
  logic          play_tick_s, spawn_hit_s, ramp_hit_s;
  logic [15:0]   lfsr_q;
  logic [23:0]   score_q, sum_s;
  logic [3:0]    speed_q;
  logic [DW-1:0] dying_cnt_q;
  logic [RW-1:0] ramp_cnt_q;
  logic [SW-1:0] spawn_cnt_q;

  assign at_end_s     = (x == 10'(WIDTH - 1)) && (y == 9'(HEIGHT - 1));
  assign start_rise_s = start && !start_q;
  assign play_tick_s  = tick_q && (state_q == PLAYING);
  assign spawn_hit_s  = play_tick_s && (spawn_cnt_q == SW'(SPAWN_GAP - 1));
  assign ramp_hit_s   = play_tick_s && (ramp_cnt_q == RW'(RAMP_FRAMES - 1));

  bcd_add_sat u_add (
    .a_i   (score_q),
    .b_i   (speed_q),
    .sum_o (sum_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start edges only matter in IDLE and OVER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rise_s) state_d = PLAYING;
        else              state_d = IDLE;
      end
      PLAYING: begin
        if (tick_q && collision) state_d = DYING;
        else                     state_d = PLAYING;
      end
      DYING: begin
        if (tick_q && (dying_cnt_q == DW'(DYING_FRAMES - 1))) state_d = OVER;
        else                                                  state_d = DYING;
      end
      OVER: begin
        if (start_rise_s) state_d = IDLE;
        else              state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; a collision or reset in the tick cycle vetoes a spawn.
  always_comb begin
    freeze  = 1'b1;
    spawn   = 1'b0;
    spawn_y = 9'd0;
    freeze  = (state_q != PLAYING);
    if (spawn_hit_s && !collision && reset) begin
      spawn   = 1'b1;
      spawn_y = SPAWN_Y_BASE + {1'b0, lfsr_q[7:0]} + {2'b00, lfsr_q[14:8]};
    end else begin
      spawn   = 1'b0;
      spawn_y = 9'd0;
    end
  end

  // Frame-tick edge detector, start edge detector, LFSR, score and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      at_end_q    <= 1'b0;
      tick_q      <= 1'b0;
      start_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      score_q     <= 24'd0;
      speed_q     <= 4'd1;
      dying_cnt_q <= '0;
      ramp_cnt_q  <= '0;
      spawn_cnt_q <= '0;
    end else begin
      at_end_q <= at_end_s;
      tick_q   <= at_end_s && !at_end_q;
      start_q  <= start;
      if (tick_q) lfsr_q <= lfsr_next(lfsr_q);
      if ((state_q == IDLE) && start_rise_s) begin
        score_q     <= 24'd0;
        speed_q     <= 4'd1;
        dying_cnt_q <= '0;
        ramp_cnt_q  <= '0;
        spawn_cnt_q <= '0;
      end else if (play_tick_s) begin
        score_q <= sum_s;
        if (collision) begin
          dying_cnt_q <= '0;
        end else begin
          if (ramp_hit_s) begin
            ramp_cnt_q <= '0;
            if (speed_q < SPEED_TOP) speed_q <= speed_q + 4'd1;
          end else begin
            ramp_cnt_q <= ramp_cnt_q + RW'(1);
          end
          if (spawn_hit_s) spawn_cnt_q <= '0;
          else             spawn_cnt_q <= spawn_cnt_q + SW'(1);
        end
      end else if (tick_q && (state_q == DYING)) begin
        dying_cnt_q <= dying_cnt_q + DW'(1);
      end
    end
  end

`ifdef SEQ_HISCORE_EN
  logic [23:0] hiscore_q;

  // Capture the final score (including the fatal tick's add) when it beats the record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hiscore_q <= 24'd0;
    end else if (play_tick_s && collision && (sum_s > hiscore_q)) begin
      hiscore_q <= sum_s;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 24'd0;
`endif

  assign frame_tick   = tick_q;
  assign state        = state_q;
  assign score        = score_q;
  assign scroll_speed = speed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes per-tick expectations,
// a monitor pops and compares whenever frame_tick is seen.
module tb_game_sequencer;
  import jetpack_pkg::*;

  localparam int DF = 3;
  localparam int RF = 2;
  localparam int SM = 3;
  localparam int SG = 4;

  logic        clk = 1'b0;
  logic        reset, start, collision;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_tick, freeze, spawn;
  game_state_t state;
  logic [3:0]  scroll_speed;
  logic [8:0]  spawn_y;
  logic [23:0] score, hiscore;
  logic [23:0] sat_a, sat_sum;
  logic [3:0]  sat_b;

  always #5 clk = ~clk;

  game_sequencer #(.DYING_FRAMES(DF), .RAMP_FRAMES(RF), .SPEED_MAX(SM), .SPAWN_GAP(SG)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .start(start), .collision(collision),
    .frame_tick(frame_tick), .state(state), .scroll_speed(scroll_speed), .freeze(freeze),
    .spawn(spawn), .spawn_y(spawn_y), .score(score), .hiscore(hiscore)
  );

  bcd_add_sat u_sat (.a_i(sat_a), .b_i(sat_b), .sum_o(sat_sum));

  typedef struct {
    logic        spawn;
    logic [8:0]  spawn_y;
    game_state_t st;
    logic [23:0] score;
    logic [3:0]  speed;
    logic [23:0] hi;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0, tick_seen = 0, spawn_seen = 0;

  // Reference model state.
  game_state_t m_state;
  int          m_score, m_hi, m_speed, m_ramp, m_spawn, m_dying;
  logic [15:0] m_lfsr;

  function automatic logic [23:0] to_bcd(input int n);
    logic [23:0] r;
    int v;
    r = 24'd0;
    v = n;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_score = 0; m_hi = 0; m_speed = 1;
    m_ramp = 0; m_spawn = 0; m_dying = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_tick(input bit coll);
    exp_t e;
    logic fb;
    e.spawn   = (m_state == PLAYING) && (m_spawn == SG - 1) && !coll;
    e.spawn_y = e.spawn ? 9'(48 + int'(m_lfsr[7:0]) + int'(m_lfsr[14:8])) : 9'd0;
    if (m_state == PLAYING) begin
      m_score = m_score + m_speed;
      if (m_score > 999999) m_score = 999999;
      if (coll) begin
        m_state = DYING; m_dying = 0;
`ifdef SEQ_HISCORE_EN
        if (m_score > m_hi) m_hi = m_score;
`endif
      end else begin
        if (m_ramp == RF - 1) begin
          m_ramp = 0;
          if (m_speed < SM) m_speed++;
        end else m_ramp++;
        if (m_spawn == SG - 1) m_spawn = 0; else m_spawn++;
      end
    end else if (m_state == DYING) begin
      if (m_dying == DF - 1) m_state = OVER; else m_dying++;
    end
    fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
    e.st = m_state; e.score = to_bcd(m_score); e.speed = 4'(m_speed); e.hi = to_bcd(m_hi);
    exp_q.push_back(e);
  endtask

  // One frame: park the pixel at the frame end for 'hold' cycles (>=2 keeps collision over the tick).
  task automatic frame(input bit coll, input int hold);
    model_tick(coll);
    @(posedge clk); #1 x = 10'd639; y = 9'd479; collision = coll;
    repeat (hold) @(posedge clk);
    #1 x = 10'd0; y = 9'd0; collision = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press(input int held);
    @(posedge clk); #1 start = 1'b1;
    repeat (held) @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (m_state == IDLE) begin
      m_state = PLAYING; m_score = 0; m_speed = 1; m_ramp = 0; m_spawn = 0; m_dying = 0;
    end else if (m_state == OVER) begin
      m_state = IDLE;
    end
  endtask

  // Monitor: on each frame_tick compare spawn outputs, then post-tick registers.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1 && reset === 1'b1) begin
        tick_seen++;
        if (spawn === 1'b1) spawn_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tick: got frame_tick with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check("spawn", 32'(spawn), 32'(e.spawn));
          check("spawn_y", 32'(spawn_y), 32'(e.spawn_y));
          @(negedge clk);
          check("tick_state", 32'(state), 32'(e.st));
          check("tick_score", 32'(score), 32'(e.score));
          check("tick_speed", 32'(scroll_speed), 32'(e.speed));
          check("tick_hiscore", 32'(hiscore), 32'(e.hi));
        end
      end
    end
  end

  initial begin
    int t0, s0;
    logic [23:0] exp_hi;
    reset = 1'b0; start = 1'b0; collision = 1'b0; x = 10'd0; y = 9'd0;
    sat_a = 24'd0; sat_b = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_score", 32'(score), 32'h0);
    check("rst_speed", 32'(scroll_speed), 32'h1);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
    check("rst_spawn", 32'(spawn), 32'h0);
    check("rst_spawn_y", 32'(spawn_y), 32'h0);
    check("rst_freeze", 32'(freeze), 32'h1);
    check("rst_hiscore", 32'(hiscore), 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Held end-of-frame pixel gives exactly one pulse; leaving and returning gives another.
    t0 = tick_seen;
    frame(1'b0, 4);
    check("hold_one_pulse", 32'(tick_seen - t0), 32'd1);
    frame(1'b0, 3);
    check("reentry_pulse", 32'(tick_seen - t0), 32'd2);

    press(2);
    check("start_state", 32'(state), 32'(PLAYING));
    check("start_freeze", 32'(freeze), 32'h0);
    check("start_score", 32'(score), 32'h0);

    // Speeds 1,1,2,2,3,3,3,3,3,3 -> 24; spawns on ticks 4 and 8.
    s0 = spawn_seen;
    for (int i = 1; i <= 10; i++) begin
      frame(1'b0, 2);
      if (i == 3) check("score_3_ticks", 32'(score), 32'h000004);
    end
    check("score_10_ticks", 32'(score), 32'h000024);
    check("speed_cap", 32'(scroll_speed), 32'h3);
    check("spawn_count", 32'(spawn_seen - s0), 32'd2);

    // Tick 12 is a spawn tick; collision on it wins but the add still lands.
    frame(1'b0, 2);
    frame(1'b1, 2);
    check("coll_state", 32'(state), 32'(DYING));
    check("coll_score", 32'(score), 32'h000030);
    check("coll_no_spawn", 32'(spawn_seen - s0), 32'd2);
    frame(1'b0, 2);
    frame(1'b0, 2);
    check("dying_hold", 32'(state), 32'(DYING));
    frame(1'b0, 2);
    check("over_state", 32'(state), 32'(OVER));
    check("over_score", 32'(score), 32'h000030);
`ifdef SEQ_HISCORE_EN
    exp_hi = 24'h000030;
`else
    exp_hi = 24'h000000;
`endif
    check("hiscore_final", 32'(hiscore), 32'(exp_hi));

    // A long start press from OVER must stop in IDLE.
    press(5);
    check("over_to_idle", 32'(state), 32'(IDLE));
    press(2);
    check("replay_state", 32'(state), 32'(PLAYING));
    check("replay_score", 32'(score), 32'h0);
    for (int i = 0; i < 3; i++) frame(1'b0, 2);

    // Reset lands in what would be a spawn tick.
    @(posedge clk); #1 x = 10'd639; y = 9'd479;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tick_present", 32'(frame_tick), 32'h1);
    check("rst_no_spawn", 32'(spawn), 32'h0);
    @(negedge clk);
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_score", 32'(score), 32'h0);
    check("midrst_speed", 32'(scroll_speed), 32'h1);
    check("midrst_hiscore", 32'(hiscore), 32'h0);
    @(posedge clk); #1 x = 10'd0; y = 9'd0;
    @(posedge clk); #1 reset = 1'b1;
    model_reset();

    // LFSR restarted from its seed: spawn_y on tick 4 follows the model.
    frame(1'b0, 2);
    press(2);
    for (int i = 0; i < 4; i++) frame(1'b0, 2);

    // Saturating adder vectors.
    sat_a = 24'h999998; sat_b = 4'd4; #1 check("sat_999998_4", 32'(sat_sum), 32'h999999);
    sat_a = 24'h000019; sat_b = 4'd15; #1 check("add_19_15", 32'(sat_sum), 32'h000034);
    sat_a = 24'h099999; sat_b = 4'd1; #1 check("add_ripple", 32'(sat_sum), 32'h100000);
    sat_a = 24'h999999; sat_b = 4'd0; #1 check("add_max_0", 32'(sat_sum), 32'h999999);
    sat_a = 24'h000007; sat_b = 4'd8; #1 check("add_7_8", 32'(sat_sum), 32'h000015);

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
